multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control state machine for the multicycle MIPS core. It decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback over multiple cycles. It drives the datapath enables and mux selects, and stalls on a memory ready handshake. It emits `aluop_sel` to steer the ALU control path; I-type ALU operations are resolved downstream by the opcode ALU-op decoder.

## Interface
- No parameters; state encoding is fixed (see Operation).
- `clk` in 1: single clock, all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op` in 6: instruction opcode bits [31:26], taken from the instruction register.
- `zero` in 1: ALU zero flag, for branch resolution.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_en` out 1: PC load enable.
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 2: write register select, 00=rt, 01=rd, 10=$31.
- `mem_to_reg` out 2: write data select, 00=ALUOut, 01=MDR, 10=PC.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: 0=PC, 1=A.
- `alu_src_b` out 2: 00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- `aluop_sel` out 2: 00=add, 01=sub, 10=funct field, 11=opcode decoder.
- `pc_source` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- State register is 4 bits, binary encoded: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, JUMP=9, ITEXE=10, ITWB=11, JAL=12. Codes 13–15 go to FETCH on the next edge, with all strobes 0.
- **FETCH**
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `aluop_sel`=00, `pc_source`=00.
  - `ir_write` and `pc_en` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `aluop_sel`=00 (branch target into ALUOut).
  - Next state by `op`:
    - 000000 → RTEXE
    - 100011 or 101011 → MEMADR
    - 000100 or 000101 → BRANCH
    - 000010 → JUMP
    - 000011 → JAL
    - 001000, 001010, 001100, 001101 → ITEXE
    - any other opcode → FETCH, with `illegal_op`=1 and `instr_done`=1.
- **MEMADR**: `alu_src_a`=1, `alu_src_b`=10, `aluop_sel`=00. Goes to MEMRD for 100011, MEMWR for 101011.
- **MEMRD**: `mem_read`=1, `iord`=1. Holds until `mem_ready`=1, then goes to MEMWB.
- **MEMWB**: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01, `instr_done`=1. Goes to FETCH.
- **MEMWR**: `mem_write`=1, `iord`=1. Holds until `mem_ready`=1; `instr_done`=`mem_ready`. Goes to FETCH.
- **RTEXE**: `alu_src_a`=1, `alu_src_b`=00, `aluop_sel`=10. Goes to RTWB.
- **RTWB**: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00, `instr_done`=1. Goes to FETCH.
- **ITEXE**: `alu_src_a`=1, `alu_src_b`=10, `aluop_sel`=11. Goes to ITWB.
- **ITWB**: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00, `instr_done`=1. Goes to FETCH.
- **BRANCH**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `aluop_sel`=01, `pc_source`=01, `instr_done`=1.
  - `pc_en`=`zero` for op 000100 and `~zero` for op 000101.
  - Goes to FETCH.
- **JUMP**: `pc_source`=10, `pc_en`=1, `instr_done`=1. Goes to FETCH.
- **JAL**: as JUMP, plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. Goes to FETCH.
- Default values: any output not listed for a state is 0 in that state.
- `op` must be held stable by the IR from DECODE until the instruction returns to FETCH. The block does not latch `op` itself.

## Timing
- Outputs are combinational decodes of the state register. Only `pc_en`, `ir_write` and `instr_done` additionally depend on `mem_ready` or `zero` (Mealy).
- Reset:
  - While `rst_n`=0, state is FETCH.
  - `pc_en`, `ir_write`, `reg_write`, `mem_read`, `mem_write`, `instr_done` and `illegal_op` are forced to 0.
  - Mux selects take their FETCH values.
  - After `rst_n` deasserts, the first rising edge evaluates from FETCH.
- Reset asserted mid-instruction (including during a memory wait):
  - The state returns to FETCH immediately.
  - No partial writeback or write strobe may appear after reset asserts.
- Cycle counts with zero-wait memory (`mem_ready` tied 1), from FETCH to `instr_done`:
  - lw: 5
  - sw, R-type, I-ALU: 4
  - beq, bne, j, jal: 3
  - illegal opcode: 2
- Each memory wait cycle adds exactly 1 cycle.
- `instr_done` occurs exactly once per instruction.

## Test plan
- R-type, `op`=000000, `mem_ready`=1 → states 0,1,6,7,0; `reg_write`=1 with `reg_dst`=01 only in cycle 4; `instr_done` in cycle 4.
- lw with `mem_ready`=0 for 2 cycles in FETCH and 3 cycles in MEMRD → `ir_write` pulses once; `instr_done` at cycle 10; `mem_to_reg`=01 in MEMWB.
- beq with `zero`=1 → `pc_en`=1 in BRANCH; bne with `zero`=1 → `pc_en`=0; both with `pc_source`=01 and `aluop_sel`=01.
- jal → JAL state shows `pc_en`=1, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `pc_source`=10; `instr_done` at cycle 3.
- `op`=111111 → `illegal_op` and `instr_done` in DECODE; back in FETCH next cycle; no `reg_write` or `mem_write` at any point.
- `rst_n` pulled low in MEMWR while `mem_ready`=0 → `mem_write`=0 within the same cycle; state is FETCH; after release, normal fetch resumes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multicycle MIPS core. It sequences fetch,
//   decode, execute, memory and writeback over several cycles, decodes the
//   6-bit opcode and stalls on the memory ready handshake.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_op[5:0]      opcode from the IR; held stable by the IR after DECODE
//   i_zero         ALU zero flag, for branch resolution
//   i_mem_ready    memory completes the current read/write this cycle
//   o_pc_en        PC load enable
//   o_iord         memory address select (0=PC, 1=ALUOut)
//   o_mem_read     memory read strobe
//   o_mem_write    memory write strobe
//   o_ir_write     instruction register load
//   o_reg_dst      write register select (00=rt, 01=rd, 10=$31)
//   o_mem_to_reg   write data select (00=ALUOut, 01=MDR, 10=PC)
//   o_reg_write    register file write enable
//   o_alu_src_a    ALU A select (0=PC, 1=A)
//   o_alu_src_b    ALU B select (00=B, 01=4, 10=imm, 11=imm<<2)
//   o_aluop_sel    ALU control (00=add, 01=sub, 10=funct, 11=opcode decoder)
//   o_pc_source    PC source (00=ALU result, 01=ALUOut, 10=jump target)
//   o_instr_done   one-cycle pulse in the final cycle of each instruction
//   o_illegal_op   one-cycle pulse in DECODE for an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_en,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_aluop_sel,
  output logic [1:0] o_pc_source,
  output logic       o_instr_done,
  output logic       o_illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ITEXE  = 4'd10,
    S_ITWB   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // Opcode dispatch out of DECODE; S_FETCH doubles as "unsupported opcode".
  function automatic state_t decode_target(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                         nxt = S_RTEXE;
      OP_LW, OP_SW:                     nxt = S_MEMADR;
      OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
      OP_J:                             nxt = S_JUMP;
      OP_JAL:                           nxt = S_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_ITEXE;
      default:                          nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  state_t r_state;

  logic       w_pc_en;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_illegal_op;

  // State register: sequencing of the instruction phases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= i_mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: r_state <= decode_target(i_op);
        S_MEMADR: begin
          if (i_op == OP_LW)      r_state <= S_MEMRD;
          else if (i_op == OP_SW) r_state <= S_MEMWR;
          else                    r_state <= S_FETCH;
        end
        S_MEMRD:  r_state <= i_mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:  r_state <= i_mem_ready ? S_FETCH : S_MEMWR;
        S_RTEXE:  r_state <= S_RTWB;
        S_ITEXE:  r_state <= S_ITWB;
        default:  r_state <= S_FETCH;  // writeback/branch/jump states and codes 13-15
      endcase
    end
  end

  // Output decode of the state; pc_en, ir_write and instr_done also see mem_ready/zero.
  always_comb begin
    w_pc_en      = 1'b0;
    o_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    o_reg_dst    = 2'b00;
    o_mem_to_reg = 2'b00;
    w_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_aluop_sel  = 2'b00;
    o_pc_source  = 2'b00;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        w_ir_write  = i_mem_ready;
        w_pc_en     = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;  // branch target into ALUOut
        if (decode_target(i_op) == S_FETCH) begin
          w_illegal_op = 1'b1;
          w_instr_done = 1'b1;
        end else begin
          w_illegal_op = 1'b0;
        end
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        o_mem_to_reg = 2'b01;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write  = 1'b1;
        o_iord       = 1'b1;
        w_instr_done = i_mem_ready;
      end
      S_RTEXE: begin
        o_alu_src_a = 1'b1;
        o_aluop_sel = 2'b10;
      end
      S_RTWB: begin
        w_reg_write  = 1'b1;
        o_reg_dst    = 2'b01;
        w_instr_done = 1'b1;
      end
      S_ITEXE: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_aluop_sel = 2'b11;
      end
      S_ITWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a  = 1'b1;
        o_aluop_sel  = 2'b01;
        o_pc_source  = 2'b01;
        w_instr_done = 1'b1;
        if (i_op == OP_BNE)      w_pc_en = ~i_zero;
        else if (i_op == OP_BEQ) w_pc_en = i_zero;
        else                     w_pc_en = 1'b0;
      end
      S_JUMP: begin
        o_pc_source  = 2'b10;
        w_pc_en      = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JAL: begin
        o_pc_source  = 2'b10;
        w_pc_en      = 1'b1;
        w_reg_write  = 1'b1;
        o_reg_dst    = 2'b10;
        o_mem_to_reg = 2'b10;
        w_instr_done = 1'b1;
      end
      default: begin
        w_pc_en = 1'b0;  // codes 13-15: everything stays at 0
      end
    endcase
  end

  // Strobes are gated by reset directly so nothing fires while rst_n is low,
  // even in the same cycle reset arrives.
  assign o_pc_en      = w_pc_en      & i_rst_n;
  assign o_mem_read   = w_mem_read   & i_rst_n;
  assign o_mem_write  = w_mem_write  & i_rst_n;
  assign o_ir_write   = w_ir_write   & i_rst_n;
  assign o_reg_write  = w_reg_write  & i_rst_n;
  assign o_instr_done = w_instr_done & i_rst_n;
  assign o_illegal_op = w_illegal_op & i_rst_n;

endmodule
